// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART/MIDI transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_fifo_pkg;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int UART_BAUD_RATE   = 38_400;
  localparam int MIDI_BAUD_RATE   = 31_250;

  typedef enum logic [2:0] {
    UART_TX_ST_IDLE   = 3'd0,
    UART_TX_ST_START  = 3'd1,
    UART_TX_ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    UART_TX_ST_PARITY = 3'd3,
`endif
    UART_TX_ST_STOP   = 3'd4
  } uart_tx_state_e;

  // Clocks per bit, rounded to nearest so the line rate error stays within half a clock.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full/empty/level come straight from the pointers.
// Read data is the entry at the read pointer, valid in the same cycle as !empty_o.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d  = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART/MIDI transmitter: FIFO, baud/bit counters, shift register, FSM, registered tx.
// Define UART_TX_PARITY_EN to append an even parity bit (11-bit frame).
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ        = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE       = UART_BAUD_RATE,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);

  uart_tx_state_e   state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .push_i    (tx_valid),
    .wr_data_i (tx_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign tx_ready = ~fifo_full;
  assign tx       = tx_q;
  assign busy     = (state_q != UART_TX_ST_IDLE) | ~fifo_empty;
  assign bit_end  = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));

  // tx_d decodes the current state, so the line lags the FSM by one clock
  // and every bit still spans exactly BAUD_DIV clocks.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      UART_TX_ST_IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rd_data;
          bit_cnt_d = '0;
          state_d   = UART_TX_ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_rd_data;
`endif
        end
      end
      UART_TX_ST_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = UART_TX_ST_DATA;
      end
      UART_TX_ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_TX_ST_PARITY;
`else
            state_d = UART_TX_ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_TX_ST_PARITY: begin
        tx_d = parity_q;
        if (bit_end) state_d = UART_TX_ST_STOP;
      end
`endif
      UART_TX_ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rd_data;
            bit_cnt_d = '0;
            state_d   = UART_TX_ST_START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_rd_data;
`endif
          end else begin
            state_d = UART_TX_ST_IDLE;
          end
        end
      end
      default: begin
        state_d    = UART_TX_ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UART_TX_ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a fast baud setting (1 MHz / 80 kbaud -> 13 clocks per bit).
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

  localparam int DIV = 13;  // (1_000_000 + 40_000) / 80_000, rounded up from 12.5
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int RX_TIMEOUT = 4 * FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  logic       par_q[$];
  int         fall_q[$];
  int         rx_bad;

  uart_tx_fifo #(
    .CLK_FREQ        (1_000_000),
    .BAUD_RATE       (80_000),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line level for frame bit index b of byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Expected tx j clocks after the accepting edge of a byte pushed while idle.
  function automatic logic exp_tx(input logic [7:0] d, input int j);
    int b;
    if (j < 2) return 1'b1;
    b = (j - 2) / DIV;
    if (b >= FRAME_BITS) return 1'b1;
    return exp_bit(d, b);
  endfunction

  task automatic rx_byte(output logic [7:0] d, output logic par, output logic ok, output int fall_cyc);
    int waited;
    d = '0; par = 1'b0; ok = 1'b1; fall_cyc = 0; waited = 0;
    while (tx !== 1'b0 && waited < RX_TIMEOUT) begin
      wait_cycles(1);
      waited++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    fall_cyc = cyc;
    wait_cycles(DIV / 2);
    if (tx !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_cycles(DIV);
      d[k] = tx;
    end
`ifdef UART_TX_PARITY_EN
    wait_cycles(DIV);
    par = tx;
`endif
    wait_cycles(DIV);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_frames(input int n);
    logic [7:0] d;
    logic       p, ok;
    int         fc;
    rx_q.delete(); par_q.delete(); fall_q.delete(); rx_bad = 0;
    for (int i = 0; i < n; i++) begin
      rx_byte(d, p, ok, fc);
      $display("rx frame %0d: data=0x%02h parity=%0b ok=%0b start_cyc=%0d", i, d, p, ok, fc);
      rx_q.push_back(d);
      par_q.push_back(p);
      fall_q.push_back(fc);
      if (!ok) rx_bad++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int waited = 0;
    while (busy !== 1'b0 && waited < RX_TIMEOUT) begin
      wait_cycles(1);
      waited++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  logic [7:0] t2_bytes [3];
  logic [7:0] t6_bytes [7];
  int n0, first_low, wave_err, n_acc, pop_edge, idle_err;

  initial begin
    t2_bytes = '{8'h90, 8'h40, 8'h20};
    t6_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    reset_n  = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(2);

    // Test 1: single byte, exact waveform, latency and busy release.
    tx_data = 8'h90; tx_valid = 1'b1;
    wait_cycles(1);
    tx_valid = 1'b0;
    check_eq("t1_level_after_push", 32'(fifo_level), 32'd1);
    check_eq("t1_busy_after_push", 32'(busy), 32'd1);
    check_eq("t1_tx_still_high", 32'(tx), 32'd1);
    first_low = -1; wave_err = 0;
    for (int j = 1; j <= FRAME_BITS * DIV + 3; j++) begin
      wait_cycles(1);
      if (tx !== exp_tx(8'h90, j)) wave_err++;
      if (first_low < 0 && tx === 1'b0) first_low = j;
      if (j == 1) check_eq("t1_level_popped", 32'(fifo_level), 32'd0);
      if (j == FRAME_BITS * DIV) check_eq("t1_busy_last_stop", 32'(busy), 32'd1);
      if (j == FRAME_BITS * DIV + 1) check_eq("t1_busy_drop", 32'(busy), 32'd0);
    end
    check_eq("t1_tx_fall_latency", 32'(first_low), 32'd2);
    check_eq("t1_wave_errors", 32'(wave_err), 32'd0);

    // Test 2: three back-to-back bytes, no idle gap.
    fork
      rx_frames(3);
      begin
        for (int i = 0; i < 3; i++) begin
          tx_data = t2_bytes[i]; tx_valid = 1'b1;
          wait_cycles(1);
        end
        tx_valid = 1'b0;
      end
    join
    check_eq("t2_frames_ok", 32'(rx_bad), 32'd0);
    for (int i = 0; i < 3; i++) check_eq($sformatf("t2_byte%0d", i), 32'(rx_q[i]), 32'(t2_bytes[i]));
    check_eq("t2_gap01", 32'(fall_q[1] - fall_q[0]), 32'(FRAME_BITS * DIV));
    check_eq("t2_gap12", 32'(fall_q[2] - fall_q[1]), 32'(FRAME_BITS * DIV));
    wait_idle("t2_idle");

    // Test 3: valid held for 20 bytes, 17 accepted; push at full ignored despite a pop.
    n_acc = 0;
    fork
      rx_frames(17);
      begin
        for (int i = 0; i < 20; i++) begin
          logic acc;
          tx_data = 8'hA0 + 8'(i); tx_valid = 1'b1;
          acc = tx_ready;
          wait_cycles(1);
          if (i == 0) n0 = cyc;
          if (acc) n_acc++;
        end
        tx_valid = 1'b0;
        check_eq("t3_accepted", 32'(n_acc), 32'd17);
        check_eq("t3_level_full", 32'(fifo_level), 32'd16);
        check_eq("t3_ready_low", 32'(tx_ready), 32'd0);
        pop_edge = n0 + 1 + FRAME_BITS * DIV;
        while (cyc < pop_edge - 1) wait_cycles(1);
        tx_data = 8'hEE; tx_valid = 1'b1;
        wait_cycles(1);
        tx_valid = 1'b0;
        check_eq("t3_push_at_full_ignored", 32'(fifo_level), 32'd15);
        check_eq("t3_ready_after_pop", 32'(tx_ready), 32'd1);
      end
    join
    check_eq("t3_frames_ok", 32'(rx_bad), 32'd0);
    for (int i = 0; i < 17; i++) check_eq($sformatf("t3_byte%0d", i), 32'(rx_q[i]), 32'hA0 + 32'(i));
    wait_cycles(DIV);
    check_eq("t3_busy_end", 32'(busy), 32'd0);
    check_eq("t3_level_end", 32'(fifo_level), 32'd0);

    // Test 4: asynchronous reset in the middle of a 0x55 frame with bytes still queued.
    tx_data = 8'h55; tx_valid = 1'b1; wait_cycles(1);
    tx_data = 8'h33; wait_cycles(1);
    tx_data = 8'h0F; wait_cycles(1);
    tx_valid = 1'b0;
    wait_cycles(4 * DIV);
    check_eq("t4_level_before_reset", 32'(fifo_level), 32'd2);
    #3 reset_n = 1'b0;
    #1;
    check_eq("t4_async_tx", 32'(tx), 32'd1);
    check_eq("t4_async_level", 32'(fifo_level), 32'd0);
    check_eq("t4_async_busy", 32'(busy), 32'd0);
    check_eq("t4_async_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(1);
    idle_err = 0;
    for (int j = 0; j < 3 * DIV; j++) begin
      wait_cycles(1);
      if (tx !== 1'b1 || busy !== 1'b0) idle_err++;
    end
    check_eq("t4_idle_after_reset", 32'(idle_err), 32'd0);

    // Test 6: push coinciding with a pop at level 5.
    fork
      rx_frames(7);
      begin
        for (int i = 0; i < 6; i++) begin
          tx_data = t6_bytes[i]; tx_valid = 1'b1;
          wait_cycles(1);
          if (i == 0) n0 = cyc;
        end
        tx_valid = 1'b0;
        pop_edge = n0 + 1 + FRAME_BITS * DIV;
        while (cyc < pop_edge - 1) wait_cycles(1);
        check_eq("t6_level_before", 32'(fifo_level), 32'd5);
        tx_data = t6_bytes[6]; tx_valid = 1'b1;
        wait_cycles(1);
        tx_valid = 1'b0;
        check_eq("t6_level_push_pop", 32'(fifo_level), 32'd5);
      end
    join
    check_eq("t6_frames_ok", 32'(rx_bad), 32'd0);
    for (int i = 0; i < 7; i++) check_eq($sformatf("t6_byte%0d", i), 32'(rx_q[i]), 32'(t6_bytes[i]));
    wait_idle("t6_idle");

`ifdef UART_TX_PARITY_EN
    // Test 5: even parity bits.
    fork
      rx_frames(2);
      begin
        tx_data = 8'h40; tx_valid = 1'b1; wait_cycles(1);
        tx_data = 8'h90; wait_cycles(1);
        tx_valid = 1'b0;
      end
    join
    check_eq("t5_frames_ok", 32'(rx_bad), 32'd0);
    check_eq("t5_byte0", 32'(rx_q[0]), 32'h40);
    check_eq("t5_parity_40", 32'(par_q[0]), 32'd1);
    check_eq("t5_byte1", 32'(rx_q[1]), 32'h90);
    check_eq("t5_parity_90", 32'(par_q[1]), 32'd0);
    check_eq("t5_gap", 32'(fall_q[1] - fall_q[0]), 32'(11 * DIV));
    wait_idle("t5_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
